delay_line: RTL and testbench

DELAY_LINE -- requirements
Module: delay_line

---
 rtl/delay_line_pkg.sv | 10 +
 rtl/delay_line_stage.sv | 37 +++
 rtl/delay_line.sv | 78 +++++++
 tb/tb_delay_line.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_line_pkg.sv
// delay_line_pkg
//   Shared constants for the delay_line block: default parameter values
//   and the value every register stage takes while rst is asserted.
package delay_line_pkg;

  localparam int DELAY_LINE_DEFAULT_WIDTH = 1;
  localparam int DELAY_LINE_DEFAULT_DELAY = 1;
  localparam int DELAY_LINE_RST_VAL       = 0;

endpackage : delay_line_pkg

// File: rtl/delay_line_stage.sv
// delay_line_stage
//   One WIDTH-bit register with asynchronous active-high reset. The
//   delay_line top chains DELAY of these to build the line.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears q to DELAY_LINE_RST_VAL
//   d   : sample captured on each rising edge of clk
//   q   : registered sample
module delay_line_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DELAY_LINE_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= WIDTH'(DELAY_LINE_RST_VAL);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : delay_line_stage

// File: rtl/delay_line.sv
// delay_line
//   Fixed-latency delay line: dout is din delayed by DELAY rising edges of
//   clk. DELAY = 0 degenerates to a wire (no registers, rst has no effect).
//   All stages clear asynchronously while rst is high, discarding any
//   in-flight samples.
// Optional build macro:
//   DELAY_LINE_VLD_EN - adds din_vld/dout_vld; the valid bit rides in the
//                       same register chain as the data so it stays in
//                       lockstep and resets to 0 with it.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   din      : WIDTH-bit sample entering the line
//   din_vld  : valid qualifier for din (DELAY_LINE_VLD_EN only)
//   dout     : WIDTH-bit sample leaving the line
//   dout_vld : din_vld delayed like din (DELAY_LINE_VLD_EN only)
module delay_line
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DELAY_LINE_DEFAULT_WIDTH,
  parameter int DELAY = DELAY_LINE_DEFAULT_DELAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
`ifdef DELAY_LINE_VLD_EN
  input  logic             din_vld,
  output logic             dout_vld,
`endif
  output logic [WIDTH-1:0] dout
);

`ifdef DELAY_LINE_VLD_EN
  localparam int CHAIN_W = WIDTH + 1;
`else
  localparam int CHAIN_W = WIDTH;
`endif

  logic [CHAIN_W-1:0] chain_in;
  logic [CHAIN_W-1:0] chain_out;

  // The valid bit occupies the MSB of the chain word; data sits below it
  // untouched, so data behaviour is the same in both builds.
`ifdef DELAY_LINE_VLD_EN
  assign chain_in = {din_vld, din};
  assign dout     = chain_out[WIDTH-1:0];
  assign dout_vld = chain_out[WIDTH];
`else
  assign chain_in = din;
  assign dout     = chain_out;
`endif

  generate
    if (DELAY == 0) begin : g_wire
      assign chain_out = chain_in;
    end else begin : g_line
      // taps[i] feeds stage i; taps[DELAY] is the registered output.
      logic [CHAIN_W-1:0] taps [DELAY+1];

      assign taps[0] = chain_in;

      for (genvar i = 0; i < DELAY; i++) begin : g_stage
        // Stage i boundary
        delay_line_stage #(
          .WIDTH (CHAIN_W)
        ) u_stage (
          .clk (clk),
          .rst (rst),
          .d   (taps[i]),
          .q   (taps[i+1])
        );
      end

      assign chain_out = taps[DELAY];
    end
  endgenerate

endmodule : delay_line

// File: tb/tb_delay_line.sv
module tb_delay_line;

  logic        clk;
  logic        rst;
  logic [7:0]  din8;
  logic [71:0] din72;
  logic        vld_in;
  logic [7:0]  dout0, dout2, dout3, dout4;
  logic [71:0] dout72;
  logic        vo0, vo2, vo3, vo4, vo72;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  delay_line #(.WIDTH(8), .DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .din(din8),
`ifdef DELAY_LINE_VLD_EN
    .din_vld(vld_in), .dout_vld(vo0),
`endif
    .dout(dout0));

  delay_line #(.WIDTH(8), .DELAY(2)) dut2 (
    .clk(clk), .rst(rst), .din(din8),
`ifdef DELAY_LINE_VLD_EN
    .din_vld(vld_in), .dout_vld(vo2),
`endif
    .dout(dout2));

  delay_line #(.WIDTH(8), .DELAY(3)) dut3 (
    .clk(clk), .rst(rst), .din(din8),
`ifdef DELAY_LINE_VLD_EN
    .din_vld(vld_in), .dout_vld(vo3),
`endif
    .dout(dout3));

  delay_line #(.WIDTH(8), .DELAY(4)) dut4 (
    .clk(clk), .rst(rst), .din(din8),
`ifdef DELAY_LINE_VLD_EN
    .din_vld(vld_in), .dout_vld(vo4),
`endif
    .dout(dout4));

  delay_line #(.WIDTH(72), .DELAY(1)) dut72 (
    .clk(clk), .rst(rst), .din(din72),
`ifdef DELAY_LINE_VLD_EN
    .din_vld(vld_in), .dout_vld(vo72),
`endif
    .dout(dout72));

`ifndef DELAY_LINE_VLD_EN
  assign vo0  = 1'b0;
  assign vo2  = 1'b0;
  assign vo3  = 1'b0;
  assign vo4  = 1'b0;
  assign vo72 = 1'b0;
`endif

  // Reference model: history of samples accepted since the last reset,
  // newest first. A line of latency D shows the sample D edges old, or 0
  // if fewer than D samples have been accepted.
  logic [7:0]  hist8  [$];
  logic [71:0] hist72 [$];
  logic        histv  [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist8.delete();
      hist72.delete();
      histv.delete();
    end else begin
      hist8.push_front(din8);
      hist72.push_front(din72);
      histv.push_front(vld_in);
      if (hist8.size() > 8) begin
        void'(hist8.pop_back());
        void'(hist72.pop_back());
        void'(histv.pop_back());
      end
    end
  end

  function automatic logic [7:0] exp8(int d);
    if (d == 0) return din8;
    if (hist8.size() >= d) return hist8[d-1];
    return 8'h00;
  endfunction

  function automatic logic exp_vld(int d);
    if (d == 0) return vld_in;
    if (histv.size() >= d) return histv[d-1];
    return 1'b0;
  endfunction

  function automatic logic [71:0] exp72();
    if (hist72.size() >= 1) return hist72[0];
    return 72'h0;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic edge_and_settle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp3;
  } vec_t;

  vec_t tab [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      tab[i].din  = 8'(i + 1);
      tab[i].exp3 = (i >= 2) ? 8'(i - 1) : 8'h00;
    end

    rst    = 1'b1;
    din8   = 8'h00;
    din72  = 72'h0;
    vld_in = 1'b0;
    #1;
    chk("reset_dout3", {64'h0, dout3}, 72'h0);
    chk("reset_dout4", {64'h0, dout4}, 72'h0);
    chk("reset_dout72", dout72, 72'h0);

    // DELAY=0 is a wire even with rst asserted
    din8 = 8'hA5;
    #1;
    chk("d0_during_rst", {64'h0, dout0}, 72'hA5);

    // Counting sequence through DELAY=3
    @(negedge clk);
    rst  = 1'b0;
    din8 = tab[0].din;
    for (int i = 0; i < 8; i++) begin
      din8 = tab[i].din;
      edge_and_settle();
      chk($sformatf("count_d3_%0d", i), {64'h0, dout3}, {64'h0, tab[i].exp3});
      chk($sformatf("count_d0_%0d", i), {64'h0, dout0}, {64'h0, tab[i].din});
    end

    // Wide line: all-ones and the top bit alone
    din72 = {72{1'b1}};
    #1;
    chk("w72_before_edge", dout72, 72'h0);
    edge_and_settle();
    chk("w72_all_ones", dout72, {72{1'b1}});
    chk("w72_bit71", {71'h0, dout72[71]}, 72'h1);
    din72 = {1'b1, 71'h0};
    edge_and_settle();
    chk("w72_msb_only", dout72, {1'b1, 71'h0});
    din72 = 72'h0;

    // Mid-stream async reset on DELAY=4 holding 0x11..0x44
    for (int i = 1; i <= 4; i++) begin
      din8 = 8'(i * 8'h11);
      edge_and_settle();
    end
    chk("d4_full", {64'h0, dout4}, 72'h11);
    #3;
    rst = 1'b1;
    #1;
    chk("d4_async_clear", {64'h0, dout4}, 72'h0);
    chk("d3_async_clear", {64'h0, dout3}, 72'h0);
    din8 = 8'h99;
    edge_and_settle();
    chk("d4_rst_held", {64'h0, dout4}, 72'h0);
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din8 = 8'h55 + 8'(i * 8'h11);
      edge_and_settle();
      chk($sformatf("d4_after_rel_%0d", i), {64'h0, dout4}, (i == 3) ? 72'h55 : 72'h0);
    end

`ifdef DELAY_LINE_VLD_EN
    // Valid chain on DELAY=2: in 1,0,1 -> out 0,0,1,0,1
    #3;
    rst = 1'b1;
    #1;
    chk("vld_reset", {71'h0, vo2}, 72'h0);
    #1;
    rst = 1'b0;
    begin
      logic pat_in  [4];
      logic pat_out [4];
      pat_in  = '{1'b1, 1'b0, 1'b1, 1'b0};
      pat_out = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
        vld_in = pat_in[i];
        din8   = 8'hC0 + 8'(i);
        edge_and_settle();
        chk($sformatf("vld_d2_%0d", i), {71'h0, vo2}, {71'h0, pat_out[i]});
        chk($sformatf("vld_d0_%0d", i), {71'h0, vo0}, {71'h0, vld_in});
      end
    end
`endif

    // Randomized run against the history model, with occasional resets
    for (int n = 0; n < 300; n++) begin
      din8   = 8'($urandom);
      din72  = {8'($urandom), $urandom, $urandom};
      vld_in = 1'($urandom);
      #1;
      chk("rnd_d0", {64'h0, dout0}, {64'h0, exp8(0)});
      edge_and_settle();
      chk("rnd_d2", {64'h0, dout2}, {64'h0, exp8(2)});
      chk("rnd_d3", {64'h0, dout3}, {64'h0, exp8(3)});
      chk("rnd_d4", {64'h0, dout4}, {64'h0, exp8(4)});
      chk("rnd_d72", dout72, exp72());
`ifdef DELAY_LINE_VLD_EN
      chk("rnd_vld2", {71'h0, vo2}, {71'h0, exp_vld(2)});
      chk("rnd_vld4", {71'h0, vo4}, {71'h0, exp_vld(4)});
`endif
      if ($urandom_range(0, 24) == 0) begin
        #1;
        rst = 1'b1;
        #1;
        chk("rnd_rst_d3", {64'h0, dout3}, 72'h0);
        chk("rnd_rst_d72", dout72, 72'h0);
        #1;
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_delay_line
